execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 189 ++++++++++++++++++
 tb/tb_execute_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, load-use interlock, branch/jump resolution
// and the EX/MEM pipeline register with a valid/ready handshake toward memory.
package execute_stage_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_EQ   = 4'd8,
        ALU_NE   = 4'd9,
        ALU_LT   = 4'd10,
        ALU_GE   = 4'd11,
        ALU_LTU  = 4'd12,
        ALU_GEU  = 4'd13,
        ALU_PC4  = 4'd14,
        ALU_PASS = 4'd15
    } alu_operation_t;
endpackage

module execute_stage
    import execute_stage_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           id_valid,
    output logic           id_ready,
    input  logic [31:0]    id_pc,
    input  logic [31:0]    id_rs1_val,
    input  logic [31:0]    id_rs2_val,
    input  logic [31:0]    id_imm,
    input  logic [4:0]     id_rs1,
    input  logic [4:0]     id_rs2,
    input  logic [4:0]     id_rd,
    input  alu_operation_t id_op,
    input  logic           id_lhs_pc,
    input  logic           id_rhs_imm,
    input  logic           id_is_branch,
    input  logic           id_is_jal,
    input  logic           id_is_jalr,
    input  logic           id_mem_read,
    input  logic           id_mem_write,
    input  logic           id_reg_write,
    input  logic           wb_fwd_valid,
    input  logic [4:0]     wb_fwd_rd,
    input  logic [31:0]    wb_fwd_data,
    output logic           ex_valid,
    input  logic           ex_ready,
    output logic [31:0]    ex_result,
    output logic [31:0]    ex_store_data,
    output logic [4:0]     ex_rd,
    output logic           ex_reg_write,
    output logic           ex_mem_read,
    output logic           ex_mem_write,
    output logic           redirect_valid,
    output logic [31:0]    redirect_pc
);

    logic        ex_valid_r;
    logic [31:0] ex_result_r;
    logic [31:0] ex_store_data_r;
    logic [4:0]  ex_rd_r;
    logic        ex_reg_write_r;
    logic        ex_mem_read_r;
    logic        ex_mem_write_r;
    logic        redirect_valid_r;
    logic [31:0] redirect_pc_r;

    logic [31:0] fwd_rs1_s;
    logic [31:0] fwd_rs2_s;
    logic [31:0] alu_lhs_s;
    logic [31:0] alu_rhs_s;
    logic [31:0] alu_result_s;
    logic [31:0] target_s;
    logic        ex_fwd_ok_s;
    logic        wb_fwd_ok_s;
    logic        load_use_s;
    logic        advance_s;
    logic        accept_s;
    logic        taken_s;

    function automatic logic [31:0] alu_f(input alu_operation_t op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
            ALU_EQ:   r = {31'd0, a == b};
            ALU_NE:   r = {31'd0, a != b};
            ALU_LT:   r = {31'd0, $signed(a) < $signed(b)};
            ALU_GE:   r = {31'd0, $signed(a) >= $signed(b)};
            ALU_LTU:  r = {31'd0, a < b};
            ALU_GEU:  r = {31'd0, a >= b};
            ALU_PC4:  r = a + 32'd4;
            ALU_PASS: r = b;
            default:  r = 32'd0;
        endcase
        return r;
    endfunction

    // A load in EX/MEM has no data yet, so it never feeds the bypass; it stalls instead.
    assign ex_fwd_ok_s = FWD_EN && ex_valid_r && ex_reg_write_r && !ex_mem_read_r;
    assign wb_fwd_ok_s = FWD_EN && wb_fwd_valid;

    // Operand bypass: EX/MEM beats WB, x0 is never bypassed.
    always_comb begin
        fwd_rs1_s = id_rs1_val;
        fwd_rs2_s = id_rs2_val;
        if (id_rs1 != 5'd0 && ex_fwd_ok_s && ex_rd_r == id_rs1) begin
            fwd_rs1_s = ex_result_r;
        end else if (id_rs1 != 5'd0 && wb_fwd_ok_s && wb_fwd_rd == id_rs1) begin
            fwd_rs1_s = wb_fwd_data;
        end else begin
            fwd_rs1_s = id_rs1_val;
        end
        if (id_rs2 != 5'd0 && ex_fwd_ok_s && ex_rd_r == id_rs2) begin
            fwd_rs2_s = ex_result_r;
        end else if (id_rs2 != 5'd0 && wb_fwd_ok_s && wb_fwd_rd == id_rs2) begin
            fwd_rs2_s = wb_fwd_data;
        end else begin
            fwd_rs2_s = id_rs2_val;
        end
    end

    assign alu_lhs_s    = id_lhs_pc  ? id_pc  : fwd_rs1_s;
    assign alu_rhs_s    = id_rhs_imm ? id_imm : fwd_rs2_s;
    assign alu_result_s = alu_f(id_op, alu_lhs_s, alu_rhs_s);

    assign load_use_s = ex_valid_r && ex_mem_read_r && (ex_rd_r != 5'd0) &&
                        ((ex_rd_r == id_rs1) || (ex_rd_r == id_rs2));
    assign advance_s  = !ex_valid_r || ex_ready;
    // During the redirect cycle the ID slot holds a wrong-path instruction: swallow it.
    assign id_ready   = redirect_valid_r || (advance_s && !load_use_s);
    assign accept_s   = id_valid && id_ready && !redirect_valid_r;
    assign taken_s    = (id_is_branch && alu_result_s[0]) || id_is_jal || id_is_jalr;
    assign target_s   = id_is_jalr ? ((fwd_rs1_s + id_imm) & 32'hFFFF_FFFE)
                                   : (id_pc + id_imm);

    // EX/MEM register and one-shot redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r       <= 1'b0;
            ex_result_r      <= 32'd0;
            ex_store_data_r  <= 32'd0;
            ex_rd_r          <= 5'd0;
            ex_reg_write_r   <= 1'b0;
            ex_mem_read_r    <= 1'b0;
            ex_mem_write_r   <= 1'b0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 32'd0;
        end else if (accept_s) begin
            ex_valid_r       <= 1'b1;
            ex_result_r      <= alu_result_s;
            ex_store_data_r  <= fwd_rs2_s;
            ex_rd_r          <= id_rd;
            ex_reg_write_r   <= id_reg_write && !id_is_branch;
            ex_mem_read_r    <= id_mem_read;
            ex_mem_write_r   <= id_mem_write;
            redirect_valid_r <= taken_s;
            redirect_pc_r    <= taken_s ? target_s : redirect_pc_r;
        end else begin
            ex_valid_r       <= ex_valid_r && !ex_ready;
            redirect_valid_r <= 1'b0;
        end
    end

    assign ex_valid       = ex_valid_r;
    assign ex_result      = ex_result_r;
    assign ex_store_data  = ex_store_data_r;
    assign ex_rd          = ex_rd_r;
    assign ex_reg_write   = ex_reg_write_r;
    assign ex_mem_read    = ex_mem_read_r;
    assign ex_mem_write   = ex_mem_write_r;
    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an instruction-level model.
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           id_valid, id_ready;
    logic [31:0]    id_pc, id_rs1_val, id_rs2_val, id_imm;
    logic [4:0]     id_rs1, id_rs2, id_rd;
    alu_operation_t id_op;
    logic           id_lhs_pc, id_rhs_imm, id_is_branch, id_is_jal, id_is_jalr;
    logic           id_mem_read, id_mem_write, id_reg_write;
    logic           wb_fwd_valid;
    logic [4:0]     wb_fwd_rd;
    logic [31:0]    wb_fwd_data;
    logic           ex_valid, ex_ready;
    logic [31:0]    ex_result, ex_store_data;
    logic [4:0]     ex_rd;
    logic           ex_reg_write, ex_mem_read, ex_mem_write;
    logic           redirect_valid;
    logic [31:0]    redirect_pc;

    int tests = 0;
    int fails = 0;

    localparam logic [7:0] F_LPC = 8'h80, F_IMM = 8'h40, F_BR = 8'h20, F_JAL = 8'h10;
    localparam logic [7:0] F_JALR = 8'h08, F_MR = 8'h04, F_MW = 8'h02, F_RW = 8'h01;

    execute_stage #(.FWD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_op(id_op),
        .id_lhs_pc(id_lhs_pc), .id_rhs_imm(id_rhs_imm), .id_is_branch(id_is_branch),
        .id_is_jal(id_is_jal), .id_is_jalr(id_is_jalr), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_v, m_rw, m_mr, m_mw, m_rv;
    logic [31:0] m_res, m_st, m_rpc;
    logic [4:0]  m_rd;

    function automatic logic [31:0] ref_alu(input alu_operation_t op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b & 32'd31);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return $unsigned($signed(a) >>> sh);
            ALU_EQ:   return (a == b) ? 32'd1 : 32'd0;
            ALU_NE:   return (a != b) ? 32'd1 : 32'd0;
            ALU_LT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_GE:   return ($signed(a) < $signed(b)) ? 32'd0 : 32'd1;
            ALU_LTU:  return (a < b) ? 32'd1 : 32'd0;
            ALU_GEU:  return (a < b) ? 32'd0 : 32'd1;
            ALU_PC4:  return a + 32'd4;
            default:  return b;
        endcase
    endfunction

    function automatic logic [31:0] ref_operand(input logic [4:0] idx, input logic [31:0] val);
        if (idx == 5'd0) return val;
        if (m_v && m_rw && !m_mr && m_rd == idx) return m_res;
        if (wb_fwd_valid && wb_fwd_rd == idx) return wb_fwd_data;
        return val;
    endfunction

    function automatic logic ref_ready();
        logic stall;
        stall = m_v && m_mr && m_rd != 5'd0 && (m_rd == id_rs1 || m_rd == id_rs2);
        if (m_rv) return 1'b1;
        return (!m_v || ex_ready) && !stall;
    endfunction

    // Model advances one instruction per accepted handshake.
    always @(posedge clk or negedge rst_n) begin
        logic [31:0] a1, a2, r;
        logic        acc, tk;
        if (!rst_n) begin
            m_v <= 1'b0; m_rw <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0; m_rv <= 1'b0;
            m_res <= 32'd0; m_st <= 32'd0; m_rpc <= 32'd0; m_rd <= 5'd0;
        end else begin
            acc = id_valid && ref_ready() && !m_rv;
            a1  = ref_operand(id_rs1, id_rs1_val);
            a2  = ref_operand(id_rs2, id_rs2_val);
            r   = ref_alu(id_op, id_lhs_pc ? id_pc : a1, id_rhs_imm ? id_imm : a2);
            tk  = (id_is_branch && r[0]) || id_is_jal || id_is_jalr;
            if (acc) begin
                m_v <= 1'b1; m_res <= r; m_st <= a2; m_rd <= id_rd;
                m_rw <= id_reg_write && !id_is_branch; m_mr <= id_mem_read; m_mw <= id_mem_write;
                m_rv <= tk;
                if (tk) m_rpc <= id_is_jalr ? ((a1 + id_imm) & ~32'd1) : (id_pc + id_imm);
            end else begin
                m_rv <= 1'b0;
                if (ex_ready) m_v <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("id_ready", {31'd0, id_ready}, {31'd0, ref_ready()});
            check("ex_valid", {31'd0, ex_valid}, {31'd0, m_v});
            check("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
            if (m_v) begin
                check("ex_result", ex_result, m_res);
                check("ex_store_data", ex_store_data, m_st);
                check("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
                check("ex_ctl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, {29'd0, m_rw, m_mr, m_mw});
            end
            if (m_rv) check("redirect_pc", redirect_pc, m_rpc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input alu_operation_t op,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                         input logic [7:0] f);
        id_valid = 1'b1; id_pc = pc; id_op = op;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_val = v1; id_rs2_val = v2; id_imm = imm;
        {id_lhs_pc, id_rhs_imm, id_is_branch, id_is_jal, id_is_jalr,
         id_mem_read, id_mem_write, id_reg_write} = f;
    endtask

    task automatic drive_random();
        int ctl;
        logic [7:0] f;
        ctl = int'($urandom_range(0, 7));
        f = 8'h00;
        if ($urandom_range(0, 1) == 1) f = f | F_RW;
        if ($urandom_range(0, 2) == 0) f = f | F_IMM;
        if (ctl == 5) f = f | F_BR;
        else if (ctl == 6) f = f | F_JAL | F_LPC;
        else if (ctl == 7) f = f | F_JALR | F_LPC;
        else if (ctl == 0) f = f | F_MR;
        else if (ctl == 1) f = f | F_MW;
        drive({$urandom_range(0, 32'h3FFF), 2'b00},
              (ctl >= 6) ? ALU_PC4 : alu_operation_t'($urandom_range(0, 15)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              $urandom, $urandom_range(0, 40),
              ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32), f);
        id_valid     = ($urandom_range(0, 9) < 7);
        ex_ready     = ($urandom_range(0, 3) != 0);
        wb_fwd_valid = $urandom_range(0, 1);
        wb_fwd_rd    = 5'($urandom_range(0, 3));
        wb_fwd_data  = $urandom;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst_n = 1'b0; ex_ready = 1'b1;
        wb_fwd_valid = 1'b0; wb_fwd_rd = 5'd0; wb_fwd_data = 32'd0;
        drive(32'd0, ALU_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 8'h00);
        id_valid = 1'b0;
        tick(); tick();
        check("reset ex_valid", {31'd0, ex_valid}, 32'd0);
        check("reset ex_result", ex_result, 32'd0);
        check("reset redirect", {redirect_pc[30:0], redirect_valid}, 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;

        // ADD x3 = x1 + x2
        drive(32'h0, ALU_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, F_RW);
        tick();
        check("add valid", {31'd0, ex_valid}, 32'd1);
        check("add result", ex_result, 32'd12);
        check("add rd", {27'd0, ex_rd}, 32'd3);

        // SUB x4 = x3 - x0, EX/MEM must beat WB
        drive(32'h4, ALU_SUB, 5'd3, 5'd0, 5'd4, 32'd0, 32'd0, 32'd0, F_RW);
        wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd3; wb_fwd_data = 32'd99;
        tick();
        check("ex over wb", ex_result, 32'd12);
        wb_fwd_valid = 1'b0;

        // LW x5 then dependent ADD x6 = x5 + x0
        drive(32'h8, ALU_ADD, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0, 32'h40, F_IMM | F_MR | F_RW);
        tick();
        check("lw in ex", {30'd0, ex_valid, ex_mem_read}, 32'd3);
        drive(32'hC, ALU_ADD, 5'd5, 5'd0, 5'd6, 32'hDEAD, 32'd0, 32'd0, F_RW);
        ex_ready = 1'b0;
        #1 check("load-use stall", {31'd0, id_ready}, 32'd0);
        tick();
        check("load held", {31'd0, ex_valid}, 32'd1);
        ex_ready = 1'b1;
        #1 check("load-use while draining", {31'd0, id_ready}, 32'd0);
        tick();
        check("load drained", {31'd0, ex_valid}, 32'd0);
        wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd5; wb_fwd_data = 32'h77;
        #1 check("ready after load", {31'd0, id_ready}, 32'd1);
        tick();
        check("wb forward", ex_result, 32'h77);
        wb_fwd_valid = 1'b0;

        // BEQ taken at 0x100, imm -8
        drive(32'h100, ALU_EQ, 5'd1, 5'd2, 5'd0, 32'd9, 32'd9, 32'hFFFF_FFF8, F_BR | F_RW);
        tick();
        check("beq redirect", {31'd0, redirect_valid}, 32'd1);
        check("beq target", redirect_pc, 32'h0F8);
        check("beq no write", {31'd0, ex_reg_write}, 32'd0);
        drive(32'h104, ALU_ADD, 5'd1, 5'd2, 5'd7, 32'd1, 32'd2, 32'd0, F_RW);
        #1 check("wrong-path ready", {31'd0, id_ready}, 32'd1);
        tick();
        check("redirect one-shot", {31'd0, redirect_valid}, 32'd0);
        check("wrong-path dropped", {26'd0, ex_valid, ex_rd}, 32'd0);

        // JALR at 0x200, rs1 = 0x1001, imm = 0x10
        drive(32'h200, ALU_PC4, 5'd1, 5'd0, 5'd1, 32'h1001, 32'd0, 32'h10, F_LPC | F_JALR | F_RW);
        tick();
        check("jalr target", redirect_pc, 32'h1010);
        check("jalr link", ex_result, 32'h204);
        id_valid = 1'b0;
        tick();
        check("jalr redirect one-shot", {31'd0, redirect_valid}, 32'd0);

        // Stall for three cycles, then reset mid-stall
        drive(32'h300, ALU_ADD, 5'd8, 5'd9, 5'd2, 32'd3, 32'd4, 32'd0, F_RW);
        tick();
        check("stall setup", ex_result, 32'd7);
        ex_ready = 1'b0;
        drive(32'h304, ALU_ADD, 5'd10, 5'd11, 5'd12, 32'd100, 32'd1, 32'd0, F_RW);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall hold", {ex_result[25:0], ex_rd, ex_valid}, {26'd7, 5'd2, 1'b1});
            check("stall id_ready", {31'd0, id_ready}, 32'd0);
        end
        #1 rst_n = 1'b0;
        #1 check("async reset", {ex_result[29:0], ex_valid, redirect_valid}, 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        ex_ready = 1'b1;
        drive(32'h400, ALU_ADD, 5'd1, 5'd1, 5'd11, 32'd1, 32'd1, 32'd0, F_RW);
        tick();
        check("accept after reset", {ex_result[30:0], ex_valid}, {31'd2, 1'b1});

        // Randomized traffic, with one asynchronous reset pulse partway through
        for (int n = 0; n < 3000; n++) begin
            tick();
            drive_random();
            if (n == 1500) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
